// File: rtl/cube_pkg.sv
// Shared types and helpers for the LED cube latch-bus capture block.
// Latency: n/a (types and combinational helpers only).
// Backpressure: n/a.
// Contents: CUBE_DIM, cap_state_t, row_t, layer_frame_t, one-hot helpers.
package cube_pkg;

   localparam int CUBE_DIM = 8;

   typedef enum logic [1:0] {IDLE, ACTIVE, FAULT} cap_state_t;

   typedef logic [7:0] row_t;
   typedef row_t [7:0] layer_frame_t;

   // Exactly one bit set.
   function automatic logic is_onehot(input logic [7:0] v);
      return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
   endfunction

   // Index of the highest set bit; only meaningful for one-hot inputs.
   function automatic logic [2:0] onehot_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/bus_sync.sv
// Flop-chain synchronizer for a bus of independent asynchronous bits.
// Latency: DEPTH clocks from input change to output.
// Backpressure: none; free-running sampler.
// Ports: clk_clk, reset_reset_n (async, active-low), d (async in), q (synced out).
module bus_sync #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 2
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/cube_bus_capture.sv
// Rebuilds the 8x8x8 LED cube frame by snooping the Layers/Latches/Data bus.
// Latency: SYNC_STAGES+1 clocks pin-to-shadow/frame/frame_done; rd_data 1 clock.
// Backpressure: none; bus pulses shorter than one clock may be missed.
// Ports: clk_clk, reset_reset_n, layers_in/latches_in/data_in (async bus),
//        rd_layer/rd_row -> rd_data, frame_done, frame_count, err_multi,
//        err_ghost, err_clr. Option macro: CUBE_CAPTURE_GHOST_CHECK_EN.
module cube_bus_capture #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [7:0]       layers_in,
   input  logic [7:0]       latches_in,
   input  logic [7:0]       data_in,
   input  logic [2:0]       rd_layer,
   input  logic [2:0]       rd_row,
   output logic [7:0]       rd_data,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_count,
   output logic             err_multi,
   output logic             err_ghost,
   input  logic             err_clr
);

   import cube_pkg::*;

   // All 24 bus lines share one chain so layer/latch/data stay mutually aligned.
   logic [23:0] bus_q;
   logic [7:0]  layers_s, latches_s, data_s;

   bus_sync #(.WIDTH(24), .DEPTH(SYNC_STAGES)) u_bus_sync (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .d             ({layers_in, latches_in, data_in}),
      .q             (bus_q)
   );

   assign layers_s  = bus_q[23:16];
   assign latches_s = bus_q[15:8];
   assign data_s    = bus_q[7:0];

   logic [7:0]   latches_prev;
   logic [7:0]   latch_rise;
   layer_frame_t shadow, shadow_nxt;
   layer_frame_t frame [CUBE_DIM];

   cap_state_t   state, state_nxt;
   logic [2:0]   cur_layer;
   logic [2:0]   commit_idx;
   logic         commit, set_multi, mask_clr;
   logic         layer_onehot, layer_multi;
   logic [7:0]   commit_mask, mask_set;
   logic         full;

   assign latch_rise = latches_s & ~latches_prev;

   // Commit must see row writes landing in the same cycle, so it uses shadow_nxt.
   always_comb begin
      shadow_nxt = shadow;
      for (int i = 0; i < CUBE_DIM; i++) begin
         if (latch_rise[i]) shadow_nxt[i] = data_s;
      end
   end

   assign layer_onehot = is_onehot(layers_s);
   assign layer_multi  = (layers_s != 8'h00) && !layer_onehot;
   assign commit_idx   = onehot_idx(layers_s);

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      set_multi = 1'b0;
      mask_clr  = 1'b0;
      case (state)
         IDLE: begin
            if (layer_onehot) begin
               commit    = 1'b1;
               state_nxt = ACTIVE;
            end else if (layer_multi) begin
               state_nxt = FAULT;
            end
         end
         ACTIVE: begin
            if (layers_s == 8'h00)             state_nxt = IDLE;
            else if (layer_multi)              state_nxt = FAULT;
            else if (commit_idx != cur_layer)  commit    = 1'b1;
         end
         FAULT: begin
            if (layers_s == 8'h00) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Flag and mask clear apply on entry and for every cycle spent in FAULT,
      // so an err_clr cannot win while the multi-hot condition persists.
      if (state == FAULT || state_nxt == FAULT) begin
         set_multi = 1'b1;
         mask_clr  = 1'b1;
      end
   end

   assign mask_set = commit_mask | (commit ? (8'h01 << commit_idx) : 8'h00);
   assign full     = commit && (mask_set == 8'hFF);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state        <= IDLE;
         cur_layer    <= 3'd0;
         latches_prev <= 8'h00;
         shadow       <= '0;
         commit_mask  <= 8'h00;
         frame_done   <= 1'b0;
         frame_count  <= '0;
         err_multi    <= 1'b0;
         rd_data      <= 8'h00;
         for (int l = 0; l < CUBE_DIM; l++) frame[l] <= '0;
      end else begin
         state        <= state_nxt;
         latches_prev <= latches_s;
         shadow       <= shadow_nxt;
         frame_done   <= full;
         if (commit) begin
            cur_layer         <= commit_idx;
            frame[commit_idx] <= shadow_nxt;
         end
         if (mask_clr || full) commit_mask <= 8'h00;
         else                  commit_mask <= mask_set;
         if (full) frame_count <= frame_count + CNT_W'(1);
         err_multi <= set_multi | (err_multi & ~err_clr);
         // Old frame contents are read here even when a commit lands this edge.
         rd_data   <= frame[rd_layer][rd_row];
      end
   end

`ifdef CUBE_CAPTURE_GHOST_CHECK_EN
   // A row rewrite while a layer is lit shows a torn image on the cube.
   logic ghost_set;
   assign ghost_set = (state == ACTIVE) && (latch_rise != 8'h00);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) err_ghost <= 1'b0;
      else                err_ghost <= ghost_set | (err_ghost & ~err_clr);
   end
`else
   assign err_ghost = 1'b0;
`endif

endmodule

// File: tb/tb_cube_bus_capture.sv
module tb_cube_bus_capture;

   localparam int CW = 4;   // narrow counter so wrap is reachable quickly

`ifdef CUBE_CAPTURE_GHOST_CHECK_EN
   localparam bit GHOST_EN = 1'b1;
`else
   localparam bit GHOST_EN = 1'b0;
`endif

   localparam int M_IDLE = 0, M_ACTIVE = 1, M_FAULT = 2;

   logic          clk_clk = 1'b0;
   logic          reset_reset_n;
   logic [7:0]    layers_in, latches_in, data_in;
   logic [2:0]    rd_layer, rd_row;
   logic [7:0]    rd_data;
   logic          frame_done;
   logic [CW-1:0] frame_count;
   logic          err_multi, err_ghost, err_clr;

   cube_bus_capture #(.SYNC_STAGES(2), .CNT_W(CW)) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .layers_in     (layers_in),
      .latches_in    (latches_in),
      .data_in       (data_in),
      .rd_layer      (rd_layer),
      .rd_row        (rd_row),
      .rd_data       (rd_data),
      .frame_done    (frame_done),
      .frame_count   (frame_count),
      .err_multi     (err_multi),
      .err_ghost     (err_ghost),
      .err_clr       (err_clr)
   );

   always #10 clk_clk = ~clk_clk;

   int passed = 0;
   int total  = 0;
   int done_seen = 0;

   always @(negedge clk_clk) if (frame_done === 1'b1) done_seen <= done_seen + 1;

   // Reference model: event-level view of the bus protocol.
   logic [7:0] m_shadow [8];
   logic [7:0] m_frame  [8][8];
   logic [7:0] m_mask;
   int         m_mode, m_cur, m_count, m_total;
   bit         m_multi, m_ghost;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   task automatic m_reset();
      for (int i = 0; i < 8; i++) begin
         m_shadow[i] = 8'h00;
         for (int j = 0; j < 8; j++) m_frame[i][j] = 8'h00;
      end
      m_mask = 8'h00; m_mode = M_IDLE; m_cur = 0; m_count = 0;
      m_multi = 0; m_ghost = 0;
   endtask

   task automatic m_commit(input int idx);
      for (int r = 0; r < 8; r++) m_frame[idx][r] = m_shadow[r];
      m_mask = m_mask | (8'h01 << idx);
      if (m_mask == 8'hFF) begin
         m_mask = 8'h00;
         m_count++;
         m_total++;
      end
   endtask

   task automatic m_apply(input logic [7:0] v);
      int idx;
      if (v == 8'h00) begin
         m_mode = M_IDLE;
      end else if ($countones(v) > 1) begin
         m_mode  = M_FAULT;
         m_multi = 1;
         m_mask  = 8'h00;
      end else if (m_mode != M_FAULT) begin
         idx = 0;
         for (int i = 0; i < 8; i++) if (v[i]) idx = i;
         if (m_mode == M_IDLE || idx != m_cur) m_commit(idx);
         m_mode = M_ACTIVE;
         m_cur  = idx;
      end
   endtask

   task automatic set_layers(input logic [7:0] v);
      layers_in = v;
      tick(5);
      m_apply(v);
   endtask

   task automatic pulse_latch(input logic [7:0] mask, input logic [7:0] d);
      data_in = d;
      tick(1);
      latches_in = mask;
      tick(2);
      latches_in = 8'h00;
      tick(4);
      if (m_mode == M_ACTIVE && GHOST_EN) m_ghost = 1;
      for (int i = 0; i < 8; i++) if (mask[i]) m_shadow[i] = d;
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(1);
      m_multi = (m_mode == M_FAULT);
      m_ghost = 0;
   endtask

   task automatic read_all(input string tag);
      for (int l = 0; l < 8; l++) begin
         for (int r = 0; r < 8; r++) begin
            rd_layer = 3'(l);
            rd_row   = 3'(r);
            tick(1);
            check($sformatf("%s rd[%0d][%0d]", tag, l, r), {24'h0, rd_data}, {24'h0, m_frame[l][r]});
         end
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, " frame_count"}, 32'(frame_count), 32'(m_count % (1 << CW)));
      check({tag, " done_pulses"}, 32'(done_seen), 32'(m_total));
      check({tag, " err_multi"}, 32'(err_multi), 32'(m_multi));
      check({tag, " err_ghost"}, 32'(err_ghost), 32'(m_ghost));
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " rd_data"}, 32'(rd_data), 32'h0);
      check({tag, " frame_done"}, 32'(frame_done), 32'h0);
      check({tag, " frame_count"}, 32'(frame_count), 32'h0);
      check({tag, " err_multi"}, 32'(err_multi), 32'h0);
      check({tag, " err_ghost"}, 32'(err_ghost), 32'h0);
   endtask

   task automatic scan_frame();
      for (int l = 0; l < 8; l++) set_layers(8'h01 << l);
   endtask

   initial begin
      int k;
      logic [7:0] v;
      reset_reset_n = 1'b0;
      layers_in = 8'h00; latches_in = 8'h00; data_in = 8'h00;
      rd_layer = 3'd0; rd_row = 3'd0; err_clr = 1'b0;
      m_total = 0;
      m_reset();

      // Reset state
      tick(3);
      check_zero_outputs("reset");
      reset_reset_n = 1'b1;
      tick(2);
      read_all("reset");

      // Load rows 0..7, commit layer 0: no frame_done yet
      for (int i = 0; i < 8; i++) pulse_latch(8'h01 << i, 8'(8'h11 * (i + 1)));
      set_layers(8'h01);
      read_all("layer0");
      check_status("layer0");

      // Remaining layers with distinct data, last one measured for latency
      for (int l = 1; l < 8; l++) begin
         set_layers(8'h00);
         for (int i = 0; i < 8; i++) pulse_latch(8'h01 << i, 8'(l * 16 + i + 8'h80));
         if (l < 7) begin
            set_layers(8'h01 << l);
         end else begin
            layers_in = 8'h80;
            k = 11;
            for (int i = 1; i <= 10; i++) begin
               @(negedge clk_clk);
               if (frame_done === 1'b1 && k == 11) k = i;
            end
            m_apply(8'h80);
            check("done_latency", 32'(k), 32'd3);
         end
      end
      read_all("frame1");
      check_status("frame1");

      // Counter wrap
      for (int f = 0; f < 15; f++) scan_frame();
      check("wrap frame_count", 32'(frame_count), 32'h0);
      check_status("wrap");

      // Multi-hot fault handling
      set_layers(8'h00);
      pulse_latch(8'hFF, 8'hA5);
      set_layers(8'h05);
      check_status("fault entry");
      clear_err();
      check_status("fault clr held");
      set_layers(8'h02);
      check_status("fault no zero");
      read_all("fault no commit");
      set_layers(8'h00);
      clear_err();
      check_status("fault exit");
      set_layers(8'h02);
      read_all("fault recommit");

      // Ghost check: latch 3 rewritten while layer 2 is lit
      set_layers(8'h04);
      pulse_latch(8'h08, 8'h3C);
      check_status("ghost");
      clear_err();
      check_status("ghost clr");

      // Randomized bus activity against the model
      for (int s = 0; s < 40; s++) begin
         case ($urandom_range(0, 4))
            0: pulse_latch(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)));
            1: set_layers(8'h01 << $urandom_range(0, 7));
            2: set_layers(8'h00);
            3: begin
               v = 8'($urandom_range(0, 255));
               set_layers(v);
            end
            default: clear_err();
         endcase
         check_status($sformatf("rand%0d", s));
      end
      read_all("rand");

      // Reset mid-scan with layer 4 held across reset
      set_layers(8'h00);
      clear_err();
      for (int l = 0; l < 5; l++) set_layers(8'h01 << l);
      #2 reset_reset_n = 1'b0;
      #1 check_zero_outputs("midreset");
      m_reset();
      tick(2);
      reset_reset_n = 1'b1;
      tick(5);
      m_apply(layers_in);
      scan_frame();
      check("midreset frame_count", 32'(frame_count), 32'h1);
      check_status("midreset");
      read_all("midreset");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
